// File: rtl/cpu_defs.sv
// Shared encodings for the multicycle CPU: opcodes, functs, FSM states and
// datapath select values used by both controller and datapath.
package cpu_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_SEXT = 2'd2;
  localparam logic [1:0] SRCB_ZEXT = 2'd3;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_R31 = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // One-hot instruction class; exactly one flag is set for any opcode/funct.
  typedef struct packed {
    logic add;
    logic sub;
    logic slt;
    logic addi;
    logic xori;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic j;
    logic jal;
    logic jr;
    logic bad;
  } op_class_t;

  function automatic logic is_rtype_alu(op_class_t c);
    return c.add | c.sub | c.slt;
  endfunction

endpackage

// File: rtl/multicycle_controller_op_classify.sv
// Combinational opcode/funct decoder producing one-hot class flags for the
// controller FSM.
module op_classify
  import cpu_defs::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output op_class_t  cls
);

  // Decode instruction class; anything unrecognised is flagged bad.
  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  cls.add = 1'b1;
          FN_SUB:  cls.sub = 1'b1;
          FN_SLT:  cls.slt = 1'b1;
          FN_JR:   cls.jr  = 1'b1;
          default: cls.bad = 1'b1;
        endcase
      end
      OP_J:    cls.j    = 1'b1;
      OP_JAL:  cls.jal  = 1'b1;
      OP_BEQ:  cls.beq  = 1'b1;
      OP_BNE:  cls.bne  = 1'b1;
      OP_ADDI: cls.addi = 1'b1;
      OP_XORI: cls.xori = 1'b1;
      OP_LW:   cls.lw   = 1'b1;
      OP_SW:   cls.sw   = 1'b1;
      default: cls.bad  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// combinational strobes, sticky illegal flag and retired-instruction counter.
module multicycle_controller
  import cpu_defs::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_we,
  output logic                ir_we,
  output logic                mem_re,
  output logic                mem_we,
  output logic                reg_we,
  output logic                addr_sel,
  output logic [1:0]          alu_src_b,
  output logic [2:0]          alu_op,
  output logic [1:0]          pc_src,
  output logic [1:0]          reg_dst,
  output logic [1:0]          wb_sel,
  output logic                illegal,
  output logic [2:0]          state,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [RETIRE_W-1:0] RET_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

  state_t                state_r;
  state_t                next_state_s;
  logic                  illegal_r;
  logic [RETIRE_W-1:0]   retired_r;
  op_class_t             cls_s;

  op_classify u_classify (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls_s)
  );

  // Next-state and strobe decode; reset forces every strobe low immediately.
  always_comb begin
    next_state_s = state_r;
    pc_we        = 1'b0;
    ir_we        = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    reg_we       = 1'b0;
    addr_sel     = 1'b0;
    alu_src_b    = SRCB_RT;
    alu_op       = ALU_ADD;
    pc_src       = PC_PLUS4;
    reg_dst      = DST_RT;
    wb_sel       = WB_ALU;
    if (reset) begin
      next_state_s = ST_FETCH;
    end else begin
      case (state_r)
        ST_FETCH: begin
          mem_re = 1'b1;
          if (mem_ready) begin
            ir_we        = 1'b1;
            pc_we        = 1'b1;
            next_state_s = ST_DECODE;
          end else begin
            next_state_s = ST_FETCH;
          end
        end
        ST_DECODE: begin
          if (cls_s.bad) begin
            next_state_s = ST_FETCH;
          end else if (cls_s.j) begin
            pc_we        = 1'b1;
            pc_src       = PC_JUMP;
            next_state_s = ST_FETCH;
          end else if (cls_s.jal) begin
            pc_we        = 1'b1;
            pc_src       = PC_JUMP;
            reg_we       = 1'b1;
            reg_dst      = DST_R31;
            wb_sel       = WB_PC4;
            next_state_s = ST_FETCH;
          end else if (cls_s.jr) begin
            pc_we        = 1'b1;
            pc_src       = PC_RS;
            next_state_s = ST_FETCH;
          end else begin
            next_state_s = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (is_rtype_alu(cls_s)) begin
            alu_src_b    = SRCB_RT;
            alu_op       = cls_s.add ? ALU_ADD : (cls_s.sub ? ALU_SUB : ALU_SLT);
            next_state_s = ST_WB;
          end else if (cls_s.addi) begin
            alu_src_b    = SRCB_SEXT;
            next_state_s = ST_WB;
          end else if (cls_s.xori) begin
            alu_src_b    = SRCB_ZEXT;
            alu_op       = ALU_XOR;
            next_state_s = ST_WB;
          end else if (cls_s.lw || cls_s.sw) begin
            alu_src_b    = SRCB_SEXT;
            next_state_s = ST_MEM;
          end else if (cls_s.beq || cls_s.bne) begin
            alu_op = ALU_SUB;
            if ((cls_s.beq && zero) || (cls_s.bne && !zero)) begin
              pc_we  = 1'b1;
              pc_src = PC_BRANCH;
            end else begin
              pc_we  = 1'b0;
            end
            next_state_s = ST_FETCH;
          end else begin
            next_state_s = ST_FETCH;
          end
        end
        ST_MEM: begin
          addr_sel = 1'b1;
          mem_re   = cls_s.lw;
          mem_we   = cls_s.sw;
          if (mem_ready) begin
            next_state_s = cls_s.lw ? ST_WB : ST_FETCH;
          end else begin
            next_state_s = ST_MEM;
          end
        end
        ST_WB: begin
          reg_we       = 1'b1;
          reg_dst      = is_rtype_alu(cls_s) ? DST_RD : DST_RT;
          wb_sel       = cls_s.lw ? WB_MEM : WB_ALU;
          next_state_s = ST_FETCH;
        end
        default: begin
          next_state_s = ST_FETCH;
        end
      endcase
    end
  end

  // State, sticky illegal flag and retire counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_FETCH;
      illegal_r <= 1'b0;
      retired_r <= '0;
    end else begin
      state_r <= next_state_s;
      if (state_r == ST_DECODE && cls_s.bad) begin
        illegal_r <= 1'b1;
      end
      if (state_r != ST_FETCH && next_state_s == ST_FETCH) begin
        retired_r <= retired_r + RET_ONE;
      end
    end
  end

  assign state   = state_r;
  assign illegal = illegal_r;
  assign retired = retired_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller: per-cycle state and
// strobe vectors with hand-computed expectations.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        pc_we, ir_we, mem_re, mem_we, reg_we, addr_sel;
  logic [1:0]  alu_src_b, pc_src, reg_dst, wb_sel;
  logic [2:0]  alu_op;
  logic        illegal;
  logic [2:0]  state;
  logic [31:0] retired;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ret = 0;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4;
  localparam logic [16:0] NONE = 17'd0;

  multicycle_controller #(.RETIRE_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .mem_re(mem_re),
    .mem_we(mem_we), .reg_we(reg_we), .addr_sel(addr_sel), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .reg_dst(reg_dst), .wb_sel(wb_sel),
    .illegal(illegal), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  wire [16:0] obs_vec = {pc_we, ir_we, mem_re, mem_we, reg_we, addr_sel,
                         alu_src_b, alu_op, pc_src, reg_dst, wb_sel};

  function automatic logic [16:0] v(input logic pcw, input logic irw, input logic mre,
                                    input logic mwe, input logic rwe, input logic asel,
                                    input logic [1:0] srcb, input logic [2:0] aop,
                                    input logic [1:0] psrc, input logic [1:0] rdst,
                                    input logic [1:0] wbs);
    return {pcw, irw, mre, mwe, rwe, asel, srcb, aop, psrc, rdst, wbs};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply inputs, check one cycle's state and strobes, then advance a clock.
  task automatic step(input string tag, input logic mr, input logic z,
                      input logic [2:0] exp_state, input logic [16:0] exp_vec);
    mem_ready = mr;
    zero      = z;
    #1;
    check({tag, ".state"}, {29'd0, state}, {29'd0, exp_state});
    check({tag, ".out"}, {15'd0, obs_vec}, {15'd0, exp_vec});
    @(posedge clk);
    #1;
  endtask

  task automatic end_instr(input string tag, input logic exp_ill);
    exp_ret++;
    check({tag, ".end_state"}, {29'd0, state}, {29'd0, S_F});
    check({tag, ".retired"}, retired, exp_ret);
    check({tag, ".illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask

  localparam logic [16:0] V_FETCH = 17'b1_1_1_0_0_0_00_000_00_00_00;

  initial begin
    reset = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.state", {29'd0, state}, {29'd0, S_F});
    check("rst.out", {15'd0, obs_vec}, {15'd0, NONE});
    check("rst.illegal", {31'd0, illegal}, 32'd0);
    check("rst.retired", retired, 32'd0);
    reset = 1'b0;

    // Fetch stall, then ADD
    set_instr(6'b000000, 6'b100000);
    step("add.fstall", 1'b0, 1'b0, S_F, v(0,0,1,0,0,0,2'd0,3'd0,2'd0,2'd0,2'd0));
    step("add.f", 1'b1, 1'b0, S_F, V_FETCH);
    step("add.d", 1'b1, 1'b0, S_D, NONE);
    step("add.e", 1'b1, 1'b0, S_E, v(0,0,0,0,0,0,2'd0,3'd0,2'd0,2'd0,2'd0));
    step("add.w", 1'b1, 1'b0, S_W, v(0,0,0,0,1,0,2'd0,3'd0,2'd0,2'd1,2'd0));
    end_instr("add", 1'b0);
    check("add.reg_we_once", {31'd0, reg_we}, 32'd0);

    // SUB and SLT exercise the remaining R-type alu_op codes
    set_instr(6'b000000, 6'b100010);
    step("sub.f", 1'b1, 1'b0, S_F, V_FETCH);
    step("sub.d", 1'b1, 1'b0, S_D, NONE);
    step("sub.e", 1'b1, 1'b0, S_E, v(0,0,0,0,0,0,2'd0,3'd1,2'd0,2'd0,2'd0));
    step("sub.w", 1'b1, 1'b0, S_W, v(0,0,0,0,1,0,2'd0,3'd0,2'd0,2'd1,2'd0));
    end_instr("sub", 1'b0);
    set_instr(6'b000000, 6'b101010);
    step("slt.f", 1'b1, 1'b0, S_F, V_FETCH);
    step("slt.d", 1'b1, 1'b0, S_D, NONE);
    step("slt.e", 1'b1, 1'b0, S_E, v(0,0,0,0,0,0,2'd0,3'd3,2'd0,2'd0,2'd0));
    step("slt.w", 1'b1, 1'b0, S_W, v(0,0,0,0,1,0,2'd0,3'd0,2'd0,2'd1,2'd0));
    end_instr("slt", 1'b0);

    // LW with three wait states in MEM: 8 cycles
    set_instr(6'b100011, 6'b000000);
    step("lw.f", 1'b1, 1'b0, S_F, V_FETCH);
    step("lw.d", 1'b1, 1'b0, S_D, NONE);
    step("lw.e", 1'b1, 1'b0, S_E, v(0,0,0,0,0,0,2'd2,3'd0,2'd0,2'd0,2'd0));
    for (int i = 0; i < 3; i++)
      step("lw.mwait", 1'b0, 1'b0, S_M, v(0,0,1,0,0,1,2'd0,3'd0,2'd0,2'd0,2'd0));
    step("lw.m", 1'b1, 1'b0, S_M, v(0,0,1,0,0,1,2'd0,3'd0,2'd0,2'd0,2'd0));
    step("lw.w", 1'b1, 1'b0, S_W, v(0,0,0,0,1,0,2'd0,3'd0,2'd0,2'd0,2'd1));
    end_instr("lw", 1'b0);

    // XORI and ADDI
    set_instr(6'b001110, 6'b010101);
    step("xori.f", 1'b1, 1'b0, S_F, V_FETCH);
    step("xori.d", 1'b1, 1'b0, S_D, NONE);
    step("xori.e", 1'b1, 1'b0, S_E, v(0,0,0,0,0,0,2'd3,3'd2,2'd0,2'd0,2'd0));
    step("xori.w", 1'b1, 1'b0, S_W, v(0,0,0,0,1,0,2'd0,3'd0,2'd0,2'd0,2'd0));
    end_instr("xori", 1'b0);
    set_instr(6'b001000, 6'b000000);
    step("addi.f", 1'b1, 1'b0, S_F, V_FETCH);
    step("addi.d", 1'b1, 1'b0, S_D, NONE);
    step("addi.e", 1'b1, 1'b0, S_E, v(0,0,0,0,0,0,2'd2,3'd0,2'd0,2'd0,2'd0));
    step("addi.w", 1'b1, 1'b0, S_W, v(0,0,0,0,1,0,2'd0,3'd0,2'd0,2'd0,2'd0));
    end_instr("addi", 1'b0);

    // Branches: taken iff (BEQ & zero) or (BNE & !zero)
    set_instr(6'b000100, 6'b000000);
    step("beq1.f", 1'b1, 1'b1, S_F, V_FETCH);
    step("beq1.d", 1'b1, 1'b1, S_D, NONE);
    step("beq1.e", 1'b1, 1'b1, S_E, v(1,0,0,0,0,0,2'd0,3'd1,2'd1,2'd0,2'd0));
    end_instr("beq1", 1'b0);
    step("beq0.f", 1'b1, 1'b0, S_F, V_FETCH);
    step("beq0.d", 1'b1, 1'b0, S_D, NONE);
    step("beq0.e", 1'b1, 1'b0, S_E, v(0,0,0,0,0,0,2'd0,3'd1,2'd0,2'd0,2'd0));
    end_instr("beq0", 1'b0);
    set_instr(6'b000101, 6'b000000);
    step("bne1.f", 1'b1, 1'b1, S_F, V_FETCH);
    step("bne1.d", 1'b1, 1'b1, S_D, NONE);
    step("bne1.e", 1'b1, 1'b1, S_E, v(0,0,0,0,0,0,2'd0,3'd1,2'd0,2'd0,2'd0));
    end_instr("bne1", 1'b0);
    step("bne0.f", 1'b1, 1'b0, S_F, V_FETCH);
    step("bne0.d", 1'b1, 1'b0, S_D, NONE);
    step("bne0.e", 1'b1, 1'b0, S_E, v(1,0,0,0,0,0,2'd0,3'd1,2'd1,2'd0,2'd0));
    end_instr("bne0", 1'b0);

    // Jumps complete in DECODE
    set_instr(6'b000011, 6'b000000);
    step("jal.f", 1'b1, 1'b0, S_F, V_FETCH);
    step("jal.d", 1'b1, 1'b0, S_D, v(1,0,0,0,1,0,2'd0,3'd0,2'd2,2'd2,2'd2));
    end_instr("jal", 1'b0);
    set_instr(6'b000000, 6'b001000);
    step("jr.f", 1'b1, 1'b0, S_F, V_FETCH);
    step("jr.d", 1'b1, 1'b0, S_D, v(1,0,0,0,0,0,2'd0,3'd0,2'd3,2'd0,2'd0));
    end_instr("jr", 1'b0);

    // Illegal opcode, then undefined funct; flag stays sticky
    set_instr(6'b111111, 6'b000000);
    step("ill.f", 1'b1, 1'b0, S_F, V_FETCH);
    step("ill.d", 1'b1, 1'b0, S_D, NONE);
    end_instr("ill", 1'b1);
    set_instr(6'b000010, 6'b000000);
    step("j.f", 1'b1, 1'b0, S_F, V_FETCH);
    step("j.d", 1'b1, 1'b0, S_D, v(1,0,0,0,0,0,2'd0,3'd0,2'd2,2'd0,2'd0));
    end_instr("j", 1'b1);
    set_instr(6'b000000, 6'b111111);
    step("illfn.f", 1'b1, 1'b0, S_F, V_FETCH);
    step("illfn.d", 1'b1, 1'b0, S_D, NONE);
    end_instr("illfn", 1'b1);

    // Reset during SW memory stall
    set_instr(6'b101011, 6'b000000);
    step("sw.f", 1'b1, 1'b0, S_F, V_FETCH);
    step("sw.d", 1'b1, 1'b0, S_D, NONE);
    step("sw.e", 1'b1, 1'b0, S_E, v(0,0,0,0,0,0,2'd2,3'd0,2'd0,2'd0,2'd0));
    step("sw.mwait", 1'b0, 1'b0, S_M, v(0,0,0,1,0,1,2'd0,3'd0,2'd0,2'd0,2'd0));
    mem_ready = 1'b0;
    #1;
    check("sw.mem_we_held", {31'd0, mem_we}, 32'd1);
    reset = 1'b1;
    #1;
    check("swrst.mem_we", {31'd0, mem_we}, 32'd0);
    check("swrst.out", {15'd0, obs_vec}, {15'd0, NONE});
    check("swrst.state", {29'd0, state}, {29'd0, S_F});
    check("swrst.retired", retired, 32'd0);
    check("swrst.illegal", {31'd0, illegal}, 32'd0);
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    #1;
    check("swrst.hold_out", {15'd0, obs_vec}, {15'd0, NONE});
    reset = 1'b0;
    exp_ret = 0;
    step("post.f", 1'b1, 1'b0, S_F, V_FETCH);
    step("post.d", 1'b1, 1'b0, S_D, NONE);
    step("post.e", 1'b1, 1'b0, S_E, v(0,0,0,0,0,0,2'd2,3'd0,2'd0,2'd0,2'd0));
    step("post.m", 1'b1, 1'b0, S_M, v(0,0,0,1,0,1,2'd0,3'd0,2'd0,2'd0,2'd0));
    end_instr("post_sw", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
